// File: rtl/mod3_rr_scheduler.sv
// mod3_rr_scheduler: round-robin shared serial mod-3 remainder engine with tagged result handshake
module mod3_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*W-1:0]           req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(NREQ)-1:0]     res_id,
    output logic [1:0]                  res_rem,
    output logic                        res_div3,
    output logic                        busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW = W > 1 ? $clog2(W) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [IDW-1:0] ptr, id, gid;
    logic [W-1:0] word;
    logic [CW-1:0] cnt;
    logic [1:0] rem, nrem;
    logic [NREQ-1:0] rot;
    logic found, b;
    assign rot = NREQ'({req_valid, req_valid} >> ptr);
    always_comb begin
        gid = '0;
        found = 1'b0;
        for (int k = NREQ-1; k >= 0; k--)
            if (rot[k]) begin
                gid = IDW'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
    end
    assign b = word[cnt];
    assign nrem = (rem == 2'd0) ? {1'b0, b} : (rem == 2'd1) ? (b ? 2'd0 : 2'd2) : (b ? 2'd2 : 2'd1);
    assign req_ready = (state == IDLE && found) ? NREQ'(1) << gid : '0;
    assign res_valid = state == DONE;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            ptr <= '0;
            id <= '0;
            word <= '0;
            rem <= '0;
            cnt <= '0;
            res_id <= '0;
            res_rem <= '0;
            res_div3 <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    word <= req_data[gid*W +: W];
                    id <= gid;
                    rem <= '0;
                    cnt <= CW'(W-1);
                    state <= SHIFT;
                end
                SHIFT: begin
                    rem <= nrem;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        res_id <= id;
                        res_rem <= nrem;
                        res_div3 <= nrem == 2'd0;
                    end
                end
                DONE: if (res_ready) begin
                    state <= IDLE;
                    ptr <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod3_rr_scheduler.sv
// tb_mod3_rr_scheduler: directed and randomized checks of the mod-3 scheduler against a word%3 model
module tb_mod3_rr_scheduler;
    localparam int NREQ = 4, W = 8, IDW = 2;
    logic clk = 0, resetn = 0;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*W-1:0] req_data = '0;
    logic res_valid, res_ready = 0, res_div3, busy;
    logic [IDW-1:0] res_id;
    logic [1:0] res_rem;
    logic [1:0] s_valid = '0, s_data = '0, s_ready;
    logic s_res_valid, s_res_ready = 0, s_id, s_div3, s_busy;
    logic [1:0] s_rem;
    int n_cmp = 0, n_bad = 0, ptr_m = 0;
    always #5 clk = ~clk;
    mod3_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_rem(res_rem), .res_div3(res_div3), .busy(busy));
    mod3_rr_scheduler #(.NREQ(2), .W(1)) dut_small (
        .clk(clk), .resetn(resetn), .req_valid(s_valid), .req_data(s_data),
        .req_ready(s_ready), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_id(s_id), .res_rem(s_rem), .res_div3(s_div3), .busy(s_busy));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction
    // called at a negedge in IDLE; returns at a negedge back in IDLE after the result handshake
    task automatic txn(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d, input int stall);
        int g, r;
        logic [W-1:0] wd;
        req_valid = v;
        req_data = d;
        res_ready = 0;
        #1;
        g = pick(v, ptr_m);
        wd = d[g*W +: W];
        r = int'(wd) % 3;
        chk("grant", 32'(req_ready), 32'(1) << g);
        chk("busy_idle", 32'(busy), 0);
        repeat (W) @(negedge clk);
        chk("no_early_valid", 32'(res_valid), 0);
        chk("busy_shift", 32'(busy), 1);
        chk("ready_shift", 32'(req_ready), 0);
        @(negedge clk);
        chk("res_valid", 32'(res_valid), 1);
        chk("res_id", 32'(res_id), g);
        chk("res_rem", 32'(res_rem), r);
        chk("res_div3", 32'(res_div3), 32'(r == 0));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_rem", 32'(res_rem), r);
            chk("hold_id", 32'(res_id), g);
            chk("ready_done", 32'(req_ready), 0);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("back_idle", 32'(busy), 0);
        ptr_m = (g + 1) % NREQ;
    endtask
    task automatic txn_small(input logic [1:0] v, input logic [1:0] d, input int g);
        s_valid = v;
        s_data = d;
        #1;
        chk("s_grant", 32'(s_ready), 32'(1) << g);
        @(negedge clk);
        chk("s_busy", 32'(s_busy), 1);
        chk("s_no_early", 32'(s_res_valid), 0);
        @(negedge clk);
        chk("s_valid", 32'(s_res_valid), 1);
        chk("s_id", 32'(s_id), g);
        chk("s_rem", 32'(s_rem), 32'(d[g]));
        chk("s_div3", 32'(s_div3), 32'(!d[g]));
        s_res_ready = 1;
        @(negedge clk);
        s_res_ready = 0;
        s_valid = '0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_rem", 32'(res_rem), 0);
        chk("rst_div3", 32'(res_div3), 0);
        resetn = 1;
        @(negedge clk);
        txn(4'b0001, 32'd9, 0);
        txn(4'b0100, 32'd10 << 16, 0);
        txn(4'b0100, 32'hFF << 16, 0);
        txn(4'b0100, 32'd0, 0);
        txn(4'b0010, 32'hA5 << 8, 5);
        for (int i = 0; i < 4; i++) txn(4'hF, $urandom, 0);
        for (int i = 0; i < 4; i++) txn(4'b0101, $urandom, 0);
        // abort a word mid-shift; it must never surface as a result
        req_valid = 4'b0100;
        req_data = $urandom;
        @(negedge clk);
        repeat (3) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        ptr_m = 0;
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(req_ready), 32'(1) << pick(4'b0100, 0));
        req_valid = '0;
        resetn = 1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(res_valid), 0);
        end
        for (int i = 0; i < 20; i++)
            txn(NREQ'($urandom_range(1, 15)), {$urandom}, $urandom_range(0, 3));
        req_valid = '0;
        txn_small(2'b01, 2'b01, 0);
        txn_small(2'b11, 2'b00, 1);
        txn_small(2'b11, 2'b11, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
